// File: rtl/elevator_scan_controller.sv
// SCAN cabin controller: latches floor requests, keeps travelling one way while
// requests remain ahead, and reverses only when nothing is left in that direction.
module elevator_scan_controller #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  arrived
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;

  localparam int TRV_W  = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);

  logic [1:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    curFloor_q, curFloor_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic                  dirUp_q, dirUp_d;
  logic                  arrived_q, arrived_d;
  logic                  stepped_q, stepped_d;
  logic [TRV_W-1:0]      travelCnt_q, travelCnt_d;
  logic [DOOR_W-1:0]     doorCnt_q, doorCnt_d;

  logic [NUM_FLOORS-1:0] hereMask, reqMask, setMask, clrMask;
  logic                  hereBit, anyAbove, anyBelow, aheadAny, reqHere;

  // Decode the request bitmask relative to the cabin position; out-of-range
  // request floors never match any bit, so they are dropped here.
  always_comb begin
    hereMask = '0;
    reqMask  = '0;
    hereBit  = 1'b0;
    anyAbove = 1'b0;
    anyBelow = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(curFloor_q)) begin
        hereMask[i] = 1'b1;
        hereBit     = pend_q[i];
      end
      if (i > int'(curFloor_q)) anyAbove = anyAbove | pend_q[i];
      if (i < int'(curFloor_q)) anyBelow = anyBelow | pend_q[i];
      if (req_valid && (i == int'(req_floor))) reqMask[i] = 1'b1;
    end
  end

  assign reqHere  = req_valid && (req_floor == curFloor_q);
  assign aheadAny = dirUp_q ? anyAbove : anyBelow;

  // stepped_q marks the cycle right after a floor step, where the new floor is
  // checked against pending (including requests latched on the step edge).
  always_comb begin
    state_d     = state_q;
    curFloor_d  = curFloor_q;
    dirUp_d     = dirUp_q;
    travelCnt_d = travelCnt_q;
    doorCnt_d   = doorCnt_q;
    stepped_d   = 1'b0;
    arrived_d   = 1'b0;
    clrMask     = '0;
    case (state_q)
      IDLE: begin
        if (hereBit) begin
          state_d   = DOOR;
          clrMask   = hereMask;
          arrived_d = 1'b1;
          doorCnt_d = '0;
        end else if (anyAbove && (dirUp_q || !anyBelow)) begin
          state_d     = MOVE;
          dirUp_d     = 1'b1;
          travelCnt_d = '0;
        end else if (anyBelow) begin
          state_d     = MOVE;
          dirUp_d     = 1'b0;
          travelCnt_d = '0;
        end
      end
      MOVE: begin
        if (stepped_q && hereBit) begin
          state_d     = DOOR;
          clrMask     = hereMask;
          arrived_d   = 1'b1;
          doorCnt_d   = '0;
          travelCnt_d = '0;
        end else if (stepped_q && !aheadAny) begin
          state_d     = IDLE;
          travelCnt_d = '0;
        end else if (travelCnt_q == TRV_W'(TRAVEL_CYCLES - 1)) begin
          travelCnt_d = '0;
          stepped_d   = 1'b1;
          if (dirUp_q && (int'(curFloor_q) < NUM_FLOORS - 1)) begin
            curFloor_d = curFloor_q + FLOOR_W'(1);
          end else if (!dirUp_q && (curFloor_q != '0)) begin
            curFloor_d = curFloor_q - FLOOR_W'(1);
          end
        end else begin
          travelCnt_d = travelCnt_q + TRV_W'(1);
        end
      end
      DOOR: begin
        if (reqHere) begin
          doorCnt_d = '0;
        end else if (doorCnt_q == DOOR_W'(DOOR_CYCLES - 1)) begin
          state_d   = IDLE;
          doorCnt_d = '0;
        end else begin
          doorCnt_d = doorCnt_q + DOOR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-floor request while the door is open only holds the door.
  assign setMask = ((state_q == DOOR) && reqHere) ? '0 : reqMask;
  assign pend_d  = (pend_q | setMask) & ~clrMask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      curFloor_q  <= '0;
      pend_q      <= '0;
      dirUp_q     <= 1'b1;
      arrived_q   <= 1'b0;
      stepped_q   <= 1'b0;
      travelCnt_q <= '0;
      doorCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      curFloor_q  <= curFloor_d;
      pend_q      <= pend_d;
      dirUp_q     <= dirUp_d;
      arrived_q   <= arrived_d;
      stepped_q   <= stepped_d;
      travelCnt_q <= travelCnt_d;
      doorCnt_q   <= doorCnt_d;
    end
  end

  assign current_floor = curFloor_q;
  assign pending       = pend_q;
  assign moving        = (state_q == MOVE);
  assign door_open     = (state_q == DOOR);
  assign dir_up        = dirUp_q;
  assign arrived       = arrived_q;
endmodule

// File: doc/elevator_scan_controller.md
ELEVATOR_SCAN_CONTROLLER -- requirements
Module: elevator_scan_controller

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of served floors (legal 2..16).
REQ-002 SHALL have parameter FLOOR_W, default 4, floor-index width (2**FLOOR_W >= NUM_FLOORS).
REQ-003 SHALL have parameter TRAVEL_CYCLES, default 16, clock cycles per one-floor move (legal >= 1).
REQ-004 SHALL have parameter DOOR_CYCLES, default 8, clock cycles door stays open (legal >= 1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  1  floor request strobe, sampled each rising edge.
REQ-008 SHALL have port req_floor  input  FLOOR_W  requested floor index, qualified by req_valid.
REQ-009 SHALL have port current_floor  output  FLOOR_W  registered cabin floor.
REQ-010 SHALL have port pending  output  NUM_FLOORS  registered outstanding-request bitmask, bit i = floor i.
REQ-011 SHALL have port moving  output  1  high while in MOVE.
REQ-012 SHALL have port dir_up  output  1  current/last travel direction, 1 = up.
REQ-013 SHALL have port door_open  output  1  high while in DOOR.
REQ-014 SHALL have port arrived  output  1  one-cycle pulse on entry to DOOR.

Function
REQ-015 SHALL implement registered states IDLE, MOVE, DOOR; moving and door_open decoded from state.
REQ-016 SHALL set pending[req_floor] on the edge where req_valid=1 and req_floor < NUM_FLOORS; req_floor >= NUM_FLOORS ignored, no state change.
REQ-017 SHALL, in DOOR, not set pending for req_floor == current_floor; such a request instead restarts the door counter to 0.
REQ-018 SHALL, in IDLE, evaluate registered pending: current floor bit set -> clear bit, DOOR, arrived=1; else any bit above and (dir_up=1 or none below) -> MOVE, dir_up=1; else any bit below -> MOVE, dir_up=0; else stay IDLE.
REQ-019 SHALL, in MOVE, count 0..TRAVEL_CYCLES-1; at terminal count step current_floor by +1 (dir_up=1) or -1 (dir_up=0) and reset counter.
REQ-020 SHALL, on the step edge, if pending bit of the new floor is set (including bits set on that same edge), go DOOR on the following edge, clear that bit, pulse arrived; else continue MOVE if any request remains in dir_up direction, else IDLE.
REQ-021 SHALL hold DOOR for DOOR_CYCLES cycles (counter 0..DOOR_CYCLES-1), then go IDLE; direction choice re-evaluated in IDLE per REQ-018 (SCAN: continue direction while requests ahead, reverse only when none ahead).
REQ-022 SHALL never drive current_floor below 0 or above NUM_FLOORS-1; no arithmetic wrap-around.
REQ-023 SHALL treat a request arriving on the same edge a bit is cleared for a different floor as independent; set and clear of different bits both take effect.
REQ-024 SHALL give latency: request accepted at edge t -> pending visible after t; IDLE reacts at edge t+1 (moving or door_open high after t+1).
REQ-025 SHALL keep dir_up unchanged in IDLE and DOOR.

Reset
REQ-026 SHALL, on rst_n low, immediately force: state IDLE, current_floor 0, pending 0, dir_up 1, moving 0, door_open 0, arrived 0, both counters 0.
REQ-027 SHALL, on reset asserted mid-MOVE or mid-DOOR, abandon all pending requests; no residual motion after rst_n deasserts.
REQ-028 SHALL ignore req_valid while rst_n low.

Verification (bench parameters NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-029 SHALL verify: reset, request floor 3 -> moving after 2 edges, current_floor 1,2,3 at 4-cycle intervals, arrived pulse once, door_open 3 cycles, pending 0, IDLE.
REQ-030 SHALL verify: at floor 0, requests 5 then 2 while passing floor 1 -> stops at 2 then 5, dir_up stays 1, two arrived pulses.
REQ-031 SHALL verify SCAN: at floor 4 moving up to 6, request 1 -> serves 6 first, then reverses dir_up=0, serves 1.
REQ-032 SHALL verify: request floor 9 (>= NUM_FLOORS) -> pending unchanged, no motion; request current floor while DOOR -> door_open extended 3 more cycles, pending bit stays 0.
REQ-033 SHALL verify: rst_n pulsed low mid-MOVE at floor 2 with pending 0x50 -> current_floor 0, pending 0, IDLE immediately, no motion after release.
